// File: rtl/ahb_grant_sequencer.sv
// ahb_grant_sequencer
//
// Registered round-robin owner of the shared AHB main-bus address phase, with
// tracking of the data-phase owner. Ownership only moves on HREADY-qualified
// edges and never inside a fixed-length burst or a locked sequence. Undefined-
// length INCR bursts are cut after MAX_HOLD accepted beats.
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   req_i           per-manager pending-transfer flags
//   htrans_i        per-manager HTRANS, manager i at [2i+1:2i]
//   hburst_i        per-manager HBURST, manager i at [3i+2:3i]
//   hmastlock_i     per-manager HMASTLOCK
//   hready_i        main-bus HREADY
//   grant_o         one-hot address-phase owner (never zero)
//   addr_id_o       binary index of grant_o
//   data_id_o       owner of the current data phase
//   data_valid_o    current data phase carries a NONSEQ/SEQ transfer
module ahb_grant_sequencer #(
    parameter int unsigned MANAGERS = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned IDW      = $clog2(MANAGERS)
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [MANAGERS-1:0]     req_i,
    input  logic [2*MANAGERS-1:0]   htrans_i,
    input  logic [3*MANAGERS-1:0]   hburst_i,
    input  logic [MANAGERS-1:0]     hmastlock_i,
    input  logic                    hready_i,
    output logic [MANAGERS-1:0]     grant_o,
    output logic [IDW-1:0]          addr_id_o,
    output logic [IDW-1:0]          data_id_o,
    output logic                    data_valid_o
);

    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstIncr   = 3'b001;

    typedef enum logic [1:0] {StArb, StBurst, StLocked} state_e;

    state_e                state_q, state_d;
    logic [MANAGERS-1:0]   grant_q, grant_d;
    logic [IDW-1:0]        addr_id_q, addr_id_d;
    logic [IDW-1:0]        data_id_q, data_id_d;
    logic                  data_valid_q, data_valid_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [3:0]            beat_cnt_q, beat_cnt_d;
    logic [HCW-1:0]        hold_cnt_q, hold_cnt_d;

    // Signals of the current address-phase owner.
    logic [1:0]            own_trans;
    logic [2:0]            own_burst;
    logic                  own_lock;

    always_comb begin
        own_trans = TransIdle;
        own_burst = 3'b000;
        own_lock  = 1'b0;
        for (int unsigned i = 0; i < MANAGERS; i++) begin
            if (addr_id_q == IDW'(i)) begin
                own_trans = htrans_i[2*i +: 2];
                own_burst = hburst_i[3*i +: 3];
                own_lock  = hmastlock_i[i];
            end
        end
    end

    // Round-robin search starting just after the last winner; the last
    // candidate examined is the pointer itself.
    logic                  arb_found;
    logic [IDW-1:0]        arb_winner;
    logic [IDW-1:0]        cand;

    always_comb begin
        arb_found  = 1'b0;
        arb_winner = ptr_q;
        cand       = '0;
        for (int unsigned i = 1; i <= MANAGERS; i++) begin
            cand = IDW'((32'(ptr_q) + i) % MANAGERS);
            if (!arb_found && req_i[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    // Remaining SEQ beats after an accepted NONSEQ of a fixed-length burst.
    logic [3:0]            burst_rem;
    logic                  burst_fixed;

    always_comb begin
        burst_fixed = (own_burst[2:1] != 2'b00);
        case (own_burst[2:1])
            2'b01:   burst_rem = 4'd3;
            2'b10:   burst_rem = 4'd7;
            2'b11:   burst_rem = 4'd15;
            default: burst_rem = 4'd0;
        endcase
    end

    logic                  arbitrate;
    logic [HCW-1:0]        hold_acc;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_id_d    = addr_id_q;
        data_id_d    = data_id_q;
        data_valid_d = data_valid_q;
        ptr_d        = ptr_q;
        beat_cnt_d   = beat_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        arbitrate    = 1'b0;
        hold_acc     = hold_cnt_q;

        if (hready_i) begin
            data_id_d    = addr_id_q;
            data_valid_d = own_trans[1];

            // Beat count including the transfer accepted on this edge.
            if (own_trans == TransNonseq) begin
                hold_acc = HCW'(1);
            end else if (own_trans == TransSeq && hold_cnt_q < HCW'(MAX_HOLD)) begin
                hold_acc = hold_cnt_q + HCW'(1);
            end

            case (state_q)
                StArb: begin
                    hold_cnt_d = hold_acc;
                    if (own_trans == TransNonseq && own_lock) begin
                        state_d = StLocked;
                    end else if (own_trans == TransNonseq && burst_fixed) begin
                        state_d    = StBurst;
                        beat_cnt_d = burst_rem;
                    end else if (own_burst == BurstIncr && own_trans != TransIdle &&
                                 hold_acc < HCW'(MAX_HOLD)) begin
                        // INCR burst still within budget (counting its NONSEQ):
                        // keep the owner so the burst is not broken up.
                    end else begin
                        arbitrate = 1'b1;
                    end
                end
                StBurst: begin
                    if (own_trans == TransSeq) begin
                        if (beat_cnt_q <= 4'd1) begin
                            state_d   = StArb;
                            arbitrate = 1'b1;
                        end else begin
                            beat_cnt_d = beat_cnt_q - 4'd1;
                        end
                    end else if (own_trans == TransIdle || own_trans == TransNonseq) begin
                        // Early termination of the burst.
                        state_d   = StArb;
                        arbitrate = 1'b1;
                    end
                end
                StLocked: begin
                    if (!own_lock) begin
                        state_d   = StArb;
                        arbitrate = 1'b1;
                    end
                end
                default: begin
                    state_d = StArb;
                end
            endcase

            if (arbitrate) begin
                hold_cnt_d = '0;
                beat_cnt_d = '0;
                // No requester: park on the current owner.
                if (arb_found) begin
                    addr_id_d = arb_winner;
                    grant_d   = MANAGERS'(1) << arb_winner;
                    ptr_d     = arb_winner;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= StArb;
            grant_q      <= MANAGERS'(1);
            addr_id_q    <= '0;
            data_id_q    <= '0;
            data_valid_q <= 1'b0;
            ptr_q        <= IDW'(MANAGERS - 1);
            beat_cnt_q   <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_id_q    <= addr_id_d;
            data_id_q    <= data_id_d;
            data_valid_q <= data_valid_d;
            ptr_q        <= ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign grant_o      = grant_q;
    assign addr_id_o    = addr_id_q;
    assign data_id_o    = data_id_q;
    assign data_valid_o = data_valid_q;

endmodule

// File: tb/tb_ahb_grant_sequencer.sv
// Directed bench for ahb_grant_sequencer with four managers and MAX_HOLD=16.
module tb_ahb_grant_sequencer;

    localparam logic [1:0] Idle   = 2'b00;
    localparam logic [1:0] Nonseq = 2'b10;
    localparam logic [1:0] Seq    = 2'b11;
    localparam logic [2:0] Single = 3'b000;
    localparam logic [2:0] Incr   = 3'b001;
    localparam logic [2:0] Wrap8  = 3'b100;
    localparam logic [2:0] Incr4  = 3'b011;
    localparam logic [2:0] Incr8  = 3'b101;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [3:0]  req;
    logic [7:0]  htrans;
    logic [11:0] hburst;
    logic [3:0]  hmastlock;
    logic        hready;
    logic [3:0]  grant;
    logic [1:0]  addr_id;
    logic [1:0]  data_id;
    logic        data_valid;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb_grant_sequencer #(
        .MANAGERS (4),
        .MAX_HOLD (16)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_i        (req),
        .htrans_i     (htrans),
        .hburst_i     (hburst),
        .hmastlock_i  (hmastlock),
        .hready_i     (hready),
        .grant_o      (grant),
        .addr_id_o    (addr_id),
        .data_id_o    (data_id),
        .data_valid_o (data_valid)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int g, input int d, input int v);
        chk({tag, ".grant"}, 32'(grant), 32'(1 << g));
        chk({tag, ".addr_id"}, 32'(addr_id), 32'(g));
        chk({tag, ".data_id"}, 32'(data_id), 32'(d));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(v));
    endtask

    task automatic set_mgr(input int m, input logic [1:0] t, input logic [2:0] b,
                           input logic l);
        htrans[2*m +: 2] = t;
        hburst[3*m +: 3] = b;
        hmastlock[m]     = l;
    endtask

    task automatic set_all(input logic [1:0] t, input logic [2:0] b);
        for (int m = 0; m < 4; m++) set_mgr(m, t, b, 1'b0);
    endtask

    initial begin
        HRESETn = 1'b0;
        req     = 4'b0000;
        hready  = 1'b1;
        set_all(Idle, Single);
        step();
        step();
        chk_out("reset", 0, 0, 0);
        HRESETn = 1'b1;

        // Parked on manager 0 with no requests.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("park%0d", i), 0, 0, 0);
        end

        // Round robin: ptr starts at 3, so manager 0 wins first.
        req = 4'b1111;
        set_all(Nonseq, Single);
        step(); chk_out("rr0", 0, 0, 1);
        step(); chk_out("rr1", 1, 0, 1);
        step(); chk_out("rr2", 2, 1, 1);
        step(); chk_out("rr3", 3, 2, 1);
        step(); chk_out("rr4", 0, 3, 1);

        // INCR4 on manager 1 with manager 2 waiting, one stall mid-burst.
        set_all(Idle, Single);
        req = 4'b0110;
        step(); chk_out("i4.arb", 1, 0, 0);
        set_mgr(1, Nonseq, Incr4, 1'b0);
        set_mgr(2, Nonseq, Single, 1'b0);
        step(); chk_out("i4.b1", 1, 1, 1);
        set_mgr(1, Seq, Incr4, 1'b0);
        step(); chk_out("i4.b2", 1, 1, 1);
        hready = 1'b0;
        req    = 4'b1001;
        step(); chk_out("i4.stall", 1, 1, 1);
        hready = 1'b1;
        req    = 4'b0110;
        step(); chk_out("i4.b3", 1, 1, 1);
        step(); chk_out("i4.b4", 2, 1, 1);

        // Endless INCR on manager 3 with manager 0 waiting: 16 beats then handover.
        set_all(Idle, Single);
        req = 4'b1001;
        set_mgr(3, Nonseq, Incr, 1'b0);
        step(); chk_out("incr.arb", 3, 2, 0);
        step(); chk_out("incr.beat1", 3, 3, 1);
        set_mgr(3, Seq, Incr, 1'b0);
        for (int b = 2; b <= 15; b++) begin
            step();
            chk_out($sformatf("incr.beat%0d", b), 3, 3, 1);
        end
        step(); chk_out("incr.beat16", 0, 3, 1);

        // Locked sequence on manager 2, released together with HREADY.
        set_all(Idle, Single);
        req = 4'b0100;
        step(); chk_out("lk.arb", 2, 0, 0);
        req = 4'b1111;
        set_all(Nonseq, Single);
        set_mgr(2, Nonseq, Single, 1'b1);
        step(); chk_out("lk.t1", 2, 2, 1);
        step(); chk_out("lk.t2", 2, 2, 1);
        set_mgr(2, Idle, Single, 1'b0);
        hready = 1'b0;
        step(); chk_out("lk.stall", 2, 2, 1);
        hready = 1'b1;
        step(); chk_out("lk.rel", 3, 2, 0);

        // INCR8 on manager 3 terminated by IDLE after three beats.
        set_mgr(3, Nonseq, Incr8, 1'b0);
        step(); chk_out("i8.b1", 3, 3, 1);
        set_mgr(3, Seq, Incr8, 1'b0);
        step(); chk_out("i8.b2", 3, 3, 1);
        step(); chk_out("i8.b3", 3, 3, 1);
        set_mgr(3, Idle, Incr8, 1'b0);
        step(); chk_out("i8.term", 0, 3, 0);

        // Asynchronous reset in the middle of a WRAP8 on manager 1.
        set_all(Idle, Single);
        req = 4'b0010;
        step(); chk_out("w8.arb", 1, 0, 0);
        req = 4'b1111;
        set_mgr(1, Nonseq, Wrap8, 1'b0);
        step(); chk_out("w8.b1", 1, 1, 1);
        set_mgr(1, Seq, Wrap8, 1'b0);
        step(); chk_out("w8.b2", 1, 1, 1);
        #3;
        HRESETn = 1'b0;
        #1;
        chk_out("w8.rst", 0, 0, 0);
        step(); chk_out("w8.rsthold", 0, 0, 0);
        HRESETn = 1'b1;
        set_all(Idle, Single);
        req = 4'b0110;
        // Pointer back at 3, so the search starts at manager 0 and picks 1.
        step(); chk_out("w8.after", 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
